// File: rtl/mux_4_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
package mux_4_scan_pkg;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned WORD_W = 4;

  localparam logic [SEL_W-1:0] SEL_FIRST = 2'b00;
  localparam logic [SEL_W-1:0] SEL_LAST  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/mux_4_scan_ctrl_settle_timer.sv
// Loadable down-counter; zero flags that the current sel window has elapsed.
module settle_timer
  import mux_4_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    zero_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;

endmodule

// File: rtl/mux_4_scan_ctrl.sv
// Steps the 4:1 mux select, samples its output per select and hands the word downstream.
module mux_4_scan_ctrl
  import mux_4_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  input  logic              mux_out,
  output logic [SEL_W-1:0]  sel,
  output logic [WORD_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              busy
);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic [WORD_W-1:0]   captured;
  logic                tmr_load, tmr_en, tmr_zero;

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (CNT_W'(SETTLE - 1)),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    word_d   = word_q;
    data_d   = data_q;
    valid_d  = valid_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    captured = word_q;
    captured[sel_q] = mux_out;

    case (state_q)
      ST_IDLE: begin
        if (start || continuous) begin
          state_d  = ST_SCAN;
          sel_d    = SEL_FIRST;
          word_d   = '0;
          tmr_load = 1'b1;
        end
      end
      ST_SCAN: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          word_d = captured;
          if (sel_q == SEL_LAST) begin
            data_d  = captured;
            valid_d = 1'b1;
            sel_d   = SEL_FIRST;
            state_d = ST_HOLD;
          end else begin
            sel_d    = sel_q + SEL_W'(1);
            tmr_load = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        // Data stays frozen until the consumer takes it
        if (valid_q && ready) begin
          valid_d = 1'b0;
          if (continuous || start) begin
            state_d  = ST_SCAN;
            sel_d    = SEL_FIRST;
            word_d   = '0;
            tmr_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_FIRST;
      word_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      word_q  <= word_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign sel   = sel_q;
  assign data  = data_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mux_4_scan_ctrl.sv
// Directed bench for mux_4_scan_ctrl at SETTLE=1 and SETTLE=3.
module tb_mux_4_scan_ctrl;

  logic       clk;
  logic       rst_n;

  logic       start1, cont1, ready1, mux_out1, valid1, busy1;
  logic [1:0] sel1;
  logic [3:0] data1;
  logic [3:0] in1;

  logic       start3, cont3, ready3, mux_out3, valid3, busy3;
  logic [1:0] sel3;
  logic [3:0] data3;

  int n_checks = 0;
  int n_err    = 0;

  mux_4_scan_ctrl #(.SETTLE(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start1),
    .continuous (cont1),
    .mux_out    (mux_out1),
    .sel        (sel1),
    .data       (data1),
    .valid      (valid1),
    .ready      (ready1),
    .busy       (busy1)
  );

  mux_4_scan_ctrl #(.SETTLE(3)) dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start3),
    .continuous (cont3),
    .mux_out    (mux_out3),
    .sel        (sel3),
    .data       (data3),
    .valid      (valid3),
    .ready      (ready3),
    .busy       (busy3)
  );

  // Behavioural 4:1 mux feeding dut1: in1 = {d, c, b, a}
  always_comb mux_out1 = in1[sel1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] target;
  logic       bitv;

  initial begin
    rst_n = 1'b0;
    start1 = 1'b0; cont1 = 1'b0; ready1 = 1'b0; in1 = 4'b0000;
    start3 = 1'b0; cont3 = 1'b0; ready3 = 1'b0; mux_out3 = 1'b0;
    repeat (2) step();
    check("rst_sel",   32'(sel1),   32'd0);
    check("rst_data",  32'(data1),  32'd0);
    check("rst_valid", 32'(valid1), 32'd0);
    check("rst_busy",  32'(busy1),  32'd0);
    rst_n = 1'b1;
    step();
    check("idle_busy", 32'(busy1), 32'd0);

    // Single shot, ready high throughout
    in1 = 4'b1010; ready1 = 1'b1; start1 = 1'b1;
    step();
    start1 = 1'b0;
    check("t1_sel_e0",  32'(sel1),  32'd0);
    check("t1_busy_e0", 32'(busy1), 32'd1);
    step(); check("t1_sel_e1", 32'(sel1), 32'd1);
    step(); check("t1_sel_e2", 32'(sel1), 32'd2);
    step();
    check("t1_sel_e3",   32'(sel1),   32'd3);
    check("t1_valid_e3", 32'(valid1), 32'd0);
    step();
    check("t1_valid_e4", 32'(valid1), 32'd1);
    check("t1_data_e4",  32'(data1),  32'hA);
    check("t1_sel_e4",   32'(sel1),   32'd0);
    step();
    check("t1_valid_e5", 32'(valid1), 32'd0);
    check("t1_busy_e5",  32'(busy1),  32'd0);

    // Stall: ready low for 5 cycles
    ready1 = 1'b0; start1 = 1'b1;
    step();
    start1 = 1'b0;
    repeat (4) step();
    check("t2_valid_e4", 32'(valid1), 32'd1);
    check("t2_data_e4",  32'(data1),  32'hA);
    in1 = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_stall_valid", 32'(valid1), 32'd1);
      check("t2_stall_data",  32'(data1),  32'hA);
    end
    ready1 = 1'b1;
    step();
    check("t2_valid_hs", 32'(valid1), 32'd0);
    check("t2_busy_hs",  32'(busy1),  32'd0);

    // Continuous mode, two words 5 cycles apart
    in1 = 4'b1010; cont1 = 1'b1; ready1 = 1'b1;
    step();
    repeat (4) step();
    check("t3_w1_valid", 32'(valid1), 32'd1);
    check("t3_w1_data",  32'(data1),  32'hA);
    in1 = 4'b0101;
    step();
    check("t3_gap_valid", 32'(valid1), 32'd0);
    check("t3_gap_busy",  32'(busy1),  32'd1);
    check("t3_gap_sel",   32'(sel1),   32'd0);
    repeat (3) step();
    check("t3_w2_early", 32'(valid1), 32'd0);
    step();
    check("t3_w2_valid", 32'(valid1), 32'd1);
    check("t3_w2_data",  32'(data1),  32'h5);
    cont1 = 1'b0;
    step();
    check("t3_end_busy", 32'(busy1), 32'd0);

    // SETTLE=3: only the value at the third edge of each window counts
    target = 4'b0110;
    start3 = 1'b1;
    mux_out3 = ~target[0];
    step();
    start3 = 1'b0;
    check("t4_busy_e0", 32'(busy3), 32'd1);
    for (int e = 0; e < 12; e++) begin
      bitv = target[e / 3];
      mux_out3 = ((e % 3) == 2) ? bitv : ~bitv;
      step();
      if (e + 1 == 3) check("t4_sel_e3", 32'(sel3), 32'd1);
      if (e + 1 == 6) check("t4_sel_e6", 32'(sel3), 32'd2);
      if (e + 1 == 11) check("t4_valid_e11", 32'(valid3), 32'd0);
    end
    check("t4_valid_e12", 32'(valid3), 32'd1);
    check("t4_data_e12",  32'(data3),  32'(target));
    check("t4_sel_e12",   32'(sel3),   32'd0);
    ready3 = 1'b1;
    step();
    check("t4_valid_hs", 32'(valid3), 32'd0);
    check("t4_busy_hs",  32'(busy3),  32'd0);

    // Asynchronous reset while sel=10
    in1 = 4'b1010; ready1 = 1'b1; start1 = 1'b1;
    step();
    start1 = 1'b0;
    step(); step();
    check("t5_sel_pre", 32'(sel1), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_sel",   32'(sel1),   32'd0);
    check("t5_rst_data",  32'(data1),  32'd0);
    check("t5_rst_valid", 32'(valid1), 32'd0);
    check("t5_rst_busy",  32'(busy1),  32'd0);
    #2 rst_n = 1'b1;
    step(); step();
    check("t5_idle_busy", 32'(busy1), 32'd0);
    in1 = 4'b1011; start1 = 1'b1;
    step();
    start1 = 1'b0;
    repeat (4) step();
    check("t5_valid", 32'(valid1), 32'd1);
    check("t5_data",  32'(data1),  32'hB);
    step();
    check("t5_done_busy", 32'(busy1), 32'd0);

    // start pulsed mid-scan is ignored
    in1 = 4'b0011; start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    check("t6_sel_e1", 32'(sel1), 32'd1);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    check("t6_sel_e2", 32'(sel1), 32'd2);
    step(); step();
    check("t6_valid", 32'(valid1), 32'd1);
    check("t6_data",  32'(data1),  32'h3);
    step();
    check("t6_busy_hs", 32'(busy1), 32'd0);
    step();
    check("t6_busy_after", 32'(busy1), 32'd0);
    check("t6_valid_after", 32'(valid1), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_4_scan_ctrl.md
# mux_4_scan_ctrl

- Sequencer that sits directly upstream of the 4:1 mux (`better_mux_4`).
- Drives the mux `sel` through 00→01→10→11 and samples the mux `out` after a programmable settle time.
- Packs the four samples into a 4-bit word and presents it downstream on a valid/ready handshake.
- Supports single-shot scans (`start`) and back-to-back continuous scanning.

## Interface
Parameters:
- `SETTLE` — default 1 — cycles each `sel` value is held before `mux_out` is sampled; legal range 1..15.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — reset, asynchronous and active-low.
- `start`  in  1  — begin one scan; ignored unless in IDLE.
- `continuous`  in  1  — when high, a new scan begins on IDLE or on handshake without needing `start`.
- `mux_out`  in  1  — output of the downstream 4:1 mux.
- `sel`  out  2  — mux select, registered.
- `data`  out  4  — bit i = `mux_out` sampled while `sel`==i.
- `valid`  out  1  — `data` is complete and stable.
- `ready`  in  1  — consumer accepts `data`.
- `busy`  out  1  — high whenever state ≠ IDLE.

## Operation
- Reset value of every output: `sel`=00, `data`=0, `valid`=0, `busy`=0.
- Internal state is cleared on reset: state=IDLE, settle counter=0, partial word=0.
- FSM states:
  - IDLE → SCAN when `start` or `continuous` is high at an edge. On that edge, `sel`←00 and counter←SETTLE−1.
  - SCAN, counter ≠ 0: decrement the counter.
  - SCAN, counter == 0: capture `mux_out` into partial-word bit `sel`.
    - If `sel`≠11: `sel`←`sel`+1 and counter←SETTLE−1.
    - If `sel`==11: `data`←completed word, `valid`←1, `sel`←00, go to HOLD.
  - HOLD: `valid` and `data` stay frozen until `valid`&&`ready`.
    - On the handshake edge, `valid`←0.
    - If `continuous`||`start` is high on that edge, go directly to SCAN with `sel`=00 and counter=SETTLE−1.
    - Otherwise go to IDLE.
- `start` is ignored in SCAN. In HOLD it counts only on the handshake edge.
- `ready` has no effect outside HOLD.
- `sel` never wraps past 11 inside a scan. The increment is 2-bit and the 11 case is handled explicitly.
- `data` changes only on the edge that asserts `valid`. It never changes while `valid`=1.
- Reset asserted mid-scan: all outputs return to reset values immediately (asynchronous) and the partial word is discarded. After deassertion the block waits in IDLE for `start`/`continuous`.

## Timing
- Start accepted at edge 0.
- `sel`=i is driven from edge i·SETTLE. The sample for `sel`=i is taken at edge (i+1)·SETTLE.
- `valid` rises after edge 4·SETTLE. With SETTLE=1, `valid` is high in the cycle after edge 4.
- The mux is combinational, so `mux_out` has SETTLE cycles to settle after each `sel` change.
- In continuous mode with `ready` held high, valid words are spaced 4·SETTLE+1 cycles apart (one HOLD cycle per word).
- `busy` rises after edge 0 and falls after the handshake edge when the block returns to IDLE.

## Structure
- Shared package `mux_4_scan_pkg` holds:
  - the state encoding (IDLE=2'd0, SCAN=2'd1, HOLD=2'd2);
  - `SEL_FIRST`=2'b00 and `SEL_LAST`=2'b11;
  - the settle counter width of 4 bits.
- One sub-module is natural: `settle_timer`, a loadable down-counter with load/enable inputs and a `zero` output. The FSM, `sel` register, and word assembly stay in the top module.

## Test plan
- Reset, SETTLE=1; a=0, b=1, c=0, d=1; pulse `start`, `ready`=1 → `sel` steps 00,01,10,11 on edges 0–3, `data`=4'b1010, `valid` high after edge 4, then IDLE with `busy`=0.
- Same inputs with `ready`=0 for 5 cycles, then 1 → `valid` stays high and `data` stays 4'b1010 for the whole stall. The handshake happens on the first `ready`=1 edge and `valid` drops the cycle after.
- `continuous`=1, `ready`=1; inputs switched to a=1, b=0, c=1, d=0 after the first word → first word 4'b1010, next word 4'b0101, words 5 cycles apart.
- SETTLE=3 with `mux_out` toggled only in the first two cycles of each `sel` window → captured bits reflect the value at the third edge of each window, and `valid` rises after edge 12.
- Assert `rst_n`=0 while `sel`=10 → `sel`, `data`, `valid`, `busy` go to 0 without waiting for a clock edge. A `start` after deassertion yields a clean full word.
- Pulse `start` at `sel`=01 mid-scan → no restart. One word is produced and the block returns to IDLE.
